// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - read-side sweep controller feeding address/data pairs to the HEX display path
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_next;
    logic [PS_W-1:0]   ps_cnt;
    logic              tick;
    logic              advance;
    logic              capture;

    // A tick only counts while running; pause masks it so pause+tick never advances.
    assign tick = !pause && (ps_cnt == PS_LAST);

    // State and read-latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_LOAD;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_next;
        end
    end

    // Next-state logic: wait out the RAM latency, then hold in SHOW until an advance request.
    always_comb begin
        state_next = state;
        lat_next   = lat_cnt;
        advance    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_LOAD: begin
                lat_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_SHOW;
                end else begin
                    lat_next = lat_cnt + LAT_W'(1);
                end
            end
            ST_SHOW: begin
                // Step is honoured only while paused; steps in LOAD/WAIT fall through unqueued.
                if (tick || (step && pause)) begin
                    advance    = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Prescaler: free-runs while not paused, restarts on every advance so a tick cannot land in LOAD/WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (pause || advance || tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Read address sweep with a one-cycle wrap pulse when leaving the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= advance && (rd_addr == ADDR_LAST);
            if (advance) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

    // Display capture: data is latched once on SHOW entry; later RAM writes to the same address show on the next pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else if (capture) begin
            disp_addr  <= rd_addr;
            disp_data  <= rd_data;
            disp_valid <= 1'b1;
        end else if (advance) begin
            disp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - scoreboard bench for ram_scan_reader with RD_LAT=1 and RD_LAT=2 lanes
module tb_ram_scan_reader;

    localparam int AW = 5;
    localparam int DW = 4;
    localparam int TD = 8;
    localparam int NL = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pause;
    logic step;

    wire [AW-1:0] rd_addr    [NL];
    wire [DW-1:0] rd_data    [NL];
    wire [AW-1:0] disp_addr  [NL];
    wire [DW-1:0] disp_data  [NL];
    wire          disp_valid [NL];
    wire          wrap       [NL];

    logic [DW-1:0] mem [NL][DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int L = g + 1;
        logic [DW-1:0] pipe1;
        logic [DW-1:0] pipe2;

        ram_scan_reader #(
            .ADDR_W  (AW),
            .DATA_W  (DW),
            .TICK_DIV(TD),
            .RD_LAT  (L)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .pause     (pause),
            .step      (step),
            .rd_addr   (rd_addr[g]),
            .rd_data   (rd_data[g]),
            .disp_addr (disp_addr[g]),
            .disp_data (disp_data[g]),
            .disp_valid(disp_valid[g]),
            .wrap      (wrap[g])
        );

        // Synchronous RAM read port with L cycles of latency
        always @(posedge clk) begin
            pipe1 <= mem[g][rd_addr[g]];
            pipe2 <= pipe1;
        end
        assign rd_data[g] = (L == 1) ? pipe1 : pipe2;
    end

    typedef struct {
        int lane;
        int due;
        int addr;
        int data;
    } exp_t;

    exp_t sbq[$];

    int cyc = 0;
    bit started = 1'b0;
    int m_addr  [NL];
    int m_since [NL];
    int m_ps    [NL];
    bit m_wrap  [NL];
    bit m_rst   [NL];

    task automatic chk(input string name, input int ln, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, ln, cyc, act, exp);
        end
    endtask

    // Reference model: address advances on tick or paused step, only once the display is settled
    initial begin
        for (int g = 0; g < NL; g++) begin
            m_addr[g] = 0; m_since[g] = 0; m_ps[g] = 0; m_wrap[g] = 0; m_rst[g] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int g = 0; g < NL; g++) begin
                int   L;
                bit   tk;
                bit   adv;
                exp_t e;
                L = g + 1;
                if (reset) begin
                    started   = 1'b1;
                    m_rst[g]  = 1'b1;
                    m_addr[g] = 0;
                    m_since[g] = 0;
                    m_ps[g]   = 0;
                    m_wrap[g] = 1'b0;
                    for (int k = sbq.size() - 1; k >= 0; k--)
                        if (sbq[k].lane == g) sbq.delete(k);
                    e.lane = g; e.due = cyc + L + 1; e.addr = 0; e.data = int'(mem[g][0]);
                    sbq.push_back(e);
                end else begin
                    m_rst[g] = 1'b0;
                    tk  = !pause && (m_ps[g] == TD - 1);
                    adv = (m_since[g] >= L + 1) && (tk || (step && pause));
                    m_wrap[g] = adv && (m_addr[g] == DEPTH - 1);
                    if (pause || adv || tk) m_ps[g] = 0;
                    else m_ps[g] = m_ps[g] + 1;
                    if (adv) begin
                        m_addr[g] = (m_addr[g] + 1) % DEPTH;
                        m_since[g] = 0;
                        e.lane = g; e.due = cyc + L + 1; e.addr = m_addr[g]; e.data = int'(mem[g][m_addr[g]]);
                        sbq.push_back(e);
                    end else if (m_since[g] < L + 1) begin
                        m_since[g] = m_since[g] + 1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge and pops the scoreboard on each new display pair
    initial begin
        int exp_da [NL];
        int exp_dd [NL];
        bit prev_v [NL];
        for (int g = 0; g < NL; g++) begin
            exp_da[g] = 0; exp_dd[g] = 0; prev_v[g] = 0;
        end
        forever begin
            @(negedge clk);
            if (started) begin
                for (int g = 0; g < NL; g++) begin
                    int L;
                    int idx;
                    L = g + 1;
                    if (m_rst[g]) begin
                        chk("reset_rd_addr", g, 32'(rd_addr[g]), 0);
                        chk("reset_disp_addr", g, 32'(disp_addr[g]), 0);
                        chk("reset_disp_data", g, 32'(disp_data[g]), 0);
                        chk("reset_disp_valid", g, 32'(disp_valid[g]), 0);
                        chk("reset_wrap", g, 32'(wrap[g]), 0);
                        exp_da[g] = 0; exp_dd[g] = 0; prev_v[g] = 0;
                    end else begin
                        chk("rd_addr", g, 32'(rd_addr[g]), m_addr[g]);
                        chk("wrap", g, 32'(wrap[g]), 32'(m_wrap[g]));
                        chk("disp_valid", g, 32'(disp_valid[g]), 32'(m_since[g] >= L + 1));
                        if (disp_valid[g] === 1'b1 && !prev_v[g]) begin
                            idx = -1;
                            for (int k = 0; k < sbq.size(); k++)
                                if (idx < 0 && sbq[k].lane == g) idx = k;
                            if (idx < 0) begin
                                chk("unexpected_capture", g, 32'(disp_addr[g]), 32'hFFFF_FFFF);
                            end else begin
                                chk("capture_cycle", g, cyc, sbq[idx].due);
                                exp_da[g] = sbq[idx].addr;
                                exp_dd[g] = sbq[idx].data;
                                sbq.delete(idx);
                            end
                        end
                        for (int k = sbq.size() - 1; k >= 0; k--) begin
                            if (sbq[k].lane == g && sbq[k].due < cyc) begin
                                chk("capture_timeout", g, cyc, sbq[k].due);
                                sbq.delete(k);
                            end
                        end
                        chk("disp_addr", g, 32'(disp_addr[g]), exp_da[g]);
                        chk("disp_data", g, 32'(disp_data[g]), exp_dd[g]);
                        prev_v[g] = (disp_valid[g] === 1'b1);
                    end
                end
            end
        end
    end

    task automatic wait_addr(input int a, input int limit);
        int n;
        n = 0;
        while (rd_addr[0] !== AW'(a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("wait_addr", 0, 32'(rd_addr[0]), a);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Stimulus: free run, pause/step, random operation, mid-sweep reset
    initial begin
        int lane0_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            mem[0][i] = DW'(i);
            mem[1][i] = DW'($urandom_range(0, 15));
        end
        reset = 1'b1;
        pause = 1'b0;
        step  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (300) @(negedge clk);

        wait_addr(5, 400);
        pause = 1'b1;
        repeat (40) @(negedge clk);
        pulse_step();
        @(negedge clk);
        pulse_step();
        repeat (10) @(negedge clk);
        pause = 1'b0;
        pulse_step();
        repeat (30) @(negedge clk);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) pause = !pause;
            step = ($urandom_range(0, 3) == 0);
        end
        pause = 1'b0;
        step  = 1'b0;

        wait_addr(17, 400);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);

        pause = 1'b1;
        repeat (10) @(negedge clk);
        lane0_cnt = 0;
        for (int k = 0; k < sbq.size(); k++) lane0_cnt++;
        chk("scoreboard_drain", 0, lane0_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
